imem_boot_loader: RTL and testbench

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

---
 rtl/imem_boot_loader.sv | 131 +++++++++++++
 tb/tb_imem_boot_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked byte frame
// and writes it word by word into instruction memory.
module imem_boot_loader #(
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              wr_en,
    output logic              proc_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        PAYLOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [31:0] MAX_N = MAX_WORDS;

    state_t            state;
    state_t            state_nx;
    logic              armed;
    logic [7:0]        len_hi;
    logic [15:0]       len;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   word_cnt;
    logic [23:0]       shift;
    logic [7:0]        csum;
    logic              accept;
    logic [15:0]       hdr_len;
    logic              last_word;

    // armed keeps in_ready low until the first edge after reset release
    assign in_ready  = armed && (state inside {HDR0, HDR1, PAYLOAD, CHECK});
    assign accept    = in_valid && in_ready;
    assign hdr_len   = {len_hi, in_data};
    assign last_word = ({{(31-ADDR_W){1'b0}}, word_cnt} + 32'd1)
                       == {16'd0, len};
    assign proc_reset = ~done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= HDR0;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (accept) begin
            unique case (state)
                HDR0: state_nx = HDR1;
                HDR1: begin
                    if ({16'd0, hdr_len} > MAX_N) begin
                        state_nx = ERROR;
                    end else if (hdr_len == 16'd0) begin
                        state_nx = CHECK;
                    end else begin
                        state_nx = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (byte_cnt == 2'd3 && last_word) begin
                        state_nx = CHECK;
                    end
                end
                CHECK: state_nx = (in_data == csum) ? DONE : ERROR;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            armed    <= 1'b0;
            len_hi   <= 8'd0;
            len      <= 16'd0;
            byte_cnt <= 2'd0;
            word_cnt <= '0;
            shift    <= 24'd0;
            csum     <= 8'd0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 32'd0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            armed <= 1'b1;
            wr_en <= 1'b0;
            done  <= (state_nx == DONE);
            error <= (state_nx == ERROR);
            if (accept && state != CHECK) begin
                csum <= csum ^ in_data;
            end
            if (accept) begin
                unique case (state)
                    HDR0: len_hi <= in_data;
                    HDR1: begin
                        len      <= hdr_len;
                        byte_cnt <= 2'd0;
                        word_cnt <= '0;
                    end
                    PAYLOAD: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shift    <= {shift[15:0], in_data};
                        if (byte_cnt == 2'd3) begin
                            wr_en    <= 1'b1;
                            wr_data  <= {shift, in_data};
                            wr_addr  <= word_cnt[ADDR_W-1:0];
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: frames, bad frames, gaps
// and mid-frame reset, checked with immediate assertions.
module tb_imem_boot_loader;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        proc_reset;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    logic [11:0] log_addr [64];
    logic [31:0] log_data [64];

    imem_boot_loader #(.ADDR_W(12), .MAX_WORDS(4096)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .proc_reset (proc_reset),
        .done       (done),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (wr_en && wr_total < 64) begin
            log_addr[wr_total] <= wr_addr;
            log_data[wr_total] <= wr_data;
            wr_total <= wr_total + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (t == 20) begin
            chk("send_timeout", 32'(t), 32'd0);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // 00 01 | DE AD BE EF | 23, optionally with random gaps
    task automatic word_frame(input int maxgap, output int lat);
        logic [7:0] fr [6];
        fr[0] = 8'h00; fr[1] = 8'h01; fr[2] = 8'hDE;
        fr[3] = 8'hAD; fr[4] = 8'hBE; fr[5] = 8'hEF;
        for (int i = 0; i < 6; i++) begin
            send(fr[i], int'($urandom_range(maxgap, 0)));
        end
        chk("wf_done_early", 32'(done), 32'd0);
        send(8'h23, int'($urandom_range(maxgap, 0)));
        lat = 0;
        while (!done && lat < 10) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    initial begin
        int base;
        int lat0;
        int lat1;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_proc_reset", 32'(proc_reset), 32'd1);
        reset = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        chk("armed_in_ready", 32'(in_ready), 32'd1);

        // two-word frame
        base = wr_total;
        send(8'h00, 0); send(8'h02, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        chk("w0_en", 32'(wr_en), 32'd1);
        chk("w0_addr", 32'(wr_addr), 32'd0);
        chk("w0_data", wr_data, 32'h11223344);
        @(posedge clock);
        #1;
        chk("w0_pulse_end", 32'(wr_en), 32'd0);
        chk("w0_data_hold", wr_data, 32'h11223344);
        send(8'hA0, 0); send(8'hB0, 2); send(8'hC0, 0); send(8'hD0, 0);
        chk("w1_addr", 32'(wr_addr), 32'd1);
        chk("w1_data", wr_data, 32'hA0B0C0D0);
        chk("w1_done_low", 32'(done), 32'd0);
        chk("w1_proc_reset", 32'(proc_reset), 32'd1);
        send(8'h46, 0);
        chk("f1_done", 32'(done), 32'd1);
        chk("f1_proc_reset", 32'(proc_reset), 32'd0);
        chk("f1_in_ready", 32'(in_ready), 32'd0);
        chk("f1_wr_count", 32'(wr_total - base), 32'd2);

        // empty frame
        do_reset();
        base = wr_total;
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        chk("f0_done", 32'(done), 32'd1);
        chk("f0_error", 32'(error), 32'd0);
        chk("f0_wr_count", 32'(wr_total - base), 32'd0);

        // bad checksum, then input ignored
        do_reset();
        send(8'h00, 0); send(8'h00, 0); send(8'h01, 0);
        chk("bad_cs_error", 32'(error), 32'd1);
        chk("bad_cs_done", 32'(done), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (4) @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("bad_cs_in_ready", 32'(in_ready), 32'd0);
        chk("bad_cs_error_hold", 32'(error), 32'd1);
        chk("bad_cs_proc_reset", 32'(proc_reset), 32'd1);

        // length 4097 exceeds limit
        do_reset();
        base = wr_total;
        send(8'h10, 0); send(8'h01, 0);
        chk("len_error", 32'(error), 32'd1);
        chk("len_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        chk("len_wr_count", 32'(wr_total - base), 32'd0);

        // one-word frame, no gaps vs random gaps
        do_reset();
        base = wr_total;
        word_frame(0, lat0);
        chk("nogap_lat", 32'(lat0), 32'd0);
        chk("nogap_wr_count", 32'(wr_total - base), 32'd1);
        chk("nogap_addr", 32'(log_addr[base]), 32'd0);
        chk("nogap_data", log_data[base], 32'hDEADBEEF);
        do_reset();
        base = wr_total;
        word_frame(5, lat1);
        chk("gap_lat", 32'(lat1), 32'(lat0));
        chk("gap_wr_count", 32'(wr_total - base), 32'd1);
        chk("gap_addr", 32'(log_addr[base]), 32'd0);
        chk("gap_data", log_data[base], 32'hDEADBEEF);

        // reset after third payload byte
        do_reset();
        send(8'h00, 0); send(8'h02, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        do_reset();
        base = wr_total;
        word_frame(0, lat0);
        chk("mid_wr_count", 32'(wr_total - base), 32'd1);
        chk("mid_addr", 32'(log_addr[base]), 32'd0);
        chk("mid_data", log_data[base], 32'hDEADBEEF);
        chk("mid_done", 32'(done), 32'd1);
        chk("mid_proc_reset", 32'(proc_reset), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
